uart_rx: RTL and testbench

UART receiver, the receive-side counterpart to the transmit path driven by baud_gen.
- Samples the asynchronous serial line using an oversampling tick from a baud_gen instance configured for OVERSAMPLE x the bit rate.
- Deframes 8N1 frames: start, DATA_BITS data bits LSB first, one stop bit.
- Presents each byte on a valid/ready output with framing and overrun error flags.

---
 rtl/uart_rx.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx -- oversampling UART receiver (start, DATA_BITS data bits LSB first,
// optional even parity bit, one stop bit).
//
// The serial line is synchronized, then sampled on sample_tick pulses coming
// from a baud_gen running at OVERSAMPLE x the bit rate. The start bit is
// confirmed at its midpoint; every later bit is sampled one full bit period
// after the previous sample, i.e. mid-bit.
//
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit between
// the data bits and the stop bit, and the parity_err output.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        synchronous active-low reset
//   sample_tick  one-clk pulse at OVERSAMPLE x bit rate
//   rx           asynchronous serial line, idle high
//   data         received byte, stable while valid=1
//   valid        data holds an unread byte
//   ready        consumer accepts data when valid && ready at a rising edge
//   frame_err    one-clk pulse: stop bit sampled low
//   overrun      one-clk pulse: byte completed while previous byte unread
//   parity_err   one-clk pulse at delivery: parity check failed (UART_RX_PARITY_EN only)
//   busy         receiver is not idle
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 overrun,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state;
    logic                   rx_meta;
    logic                   rx_s;
    logic [TICK_W-1:0]      tick_cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic [DATA_BITS-1:0]   shift_reg;
`ifdef UART_RX_PARITY_EN
    logic                   parity_bit;
`endif

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it is just the highest-priority branch
        // of the clocked block; every register, including the synchronizer,
        // is given its reset value here so a mid-frame reset leaves nothing behind.
        if (!reset) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            state      <= S_IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            data       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;

            // Error flags are single-clock pulses.
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif

            // NOTE: with non-blocking assignments the last write in the block
            // wins, so a delivery in the STOP branch below overrides this
            // clear when a byte is consumed and a new one lands on the same edge.
            if (valid && ready)
                valid <= 1'b0;

            if (sample_tick) begin
                case (state)
                    S_IDLE: begin
                        if (!rx_s) begin
                            state    <= S_START;
                            tick_cnt <= '0;
                            busy     <= 1'b1;
                        end
                    end

                    S_START: begin
                        if (tick_cnt == TICK_MID) begin
                            if (!rx_s) begin
                                state    <= S_DATA;
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                            end else begin
                                // Line went back high: glitch, not a start bit.
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    S_DATA: begin
                        if (tick_cnt == TICK_LAST) begin
                            shift_reg[bit_cnt] <= rx_s;
                            tick_cnt           <= '0;
                            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= S_PARITY;
`else
                                state <= S_STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        if (tick_cnt == TICK_LAST) begin
                            parity_bit <= rx_s;
                            tick_cnt   <= '0;
                            state      <= S_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
`endif

                    S_STOP: begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            if (rx_s) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                                // A slot is free if empty or being read this edge.
                                if (!valid || ready) begin
                                    data  <= shift_reg;
                                    valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                                    parity_err <= ^{shift_reg, parity_bit};
`endif
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end else begin
                                // Low stop bit: drop the byte and wait out the break.
                                frame_err <= 1'b1;
                                state     <= S_BREAK;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    S_BREAK: begin
                        if (rx_s) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end

                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed bench for uart_rx with OVERSAMPLE=16 and sample_tick
// held high, so one bit lasts 16 clk. Expected bytes are queued by the
// stimulus; a monitor on the falling edge pops and compares each byte the
// receiver presents and counts error pulses. Inputs change 1 ns after the
// rising edge.
module tb_uart_rx;

    logic       clk         = 1'b0;
    logic       reset       = 1'b0;
    logic       sample_tick = 1'b1;
    logic       rx          = 1'b1;
    logic       ready       = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    // Rising edge, counted from the start-bit drive, on which the stop bit is sampled.
    localparam int STOP_EDGE = 171;
`else
    localparam int STOP_EDGE = 155;
`endif

    uart_rx #(
        .DATA_BITS (8),
        .OVERSAMPLE(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sample_tick(sample_tick),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int         n_checks   = 0;
    int         n_fail     = 0;
    int         n_present  = 0;
    int         n_valid_hi = 0;
    int         fe_cnt     = 0;
    int         ov_cnt     = 0;
    int         pe_cnt     = 0;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(16);
    endtask

    // bad_par inverts the even-parity bit when the parity feature is built in.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++)
            send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^b) ^ bad_par);
`endif
        send_bit(stop_bit);
    endtask

    // Monitor: a byte is newly presented when valid is high and either it was
    // low before or the previous byte was accepted on the edge in between.
    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun)   ov_cnt++;
`ifdef UART_RX_PARITY_EN
        if (parity_err) pe_cnt++;
`endif
        if (frame_err || overrun)
            check("fe_ov_exclusive", {31'b0, frame_err & overrun}, 32'd0);
        if (valid) n_valid_hi++;
        if (valid && (!prev_valid || prev_ready)) begin
            n_present++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_byte: got data=0x%0h, expected no byte", data);
            end else begin
                check("byte", {24'b0, data}, {24'b0, exp_q.pop_front()});
            end
        end
        prev_valid = valid;
        prev_ready = ready;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        reset = 1'b0;
        tick(3);
        @(negedge clk);
        check("rst_data",      {24'b0, data}, 32'h0);
        check("rst_valid",     valid,     0);
        check("rst_busy",      busy,      0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun",   overrun,   0);
        tick(1);
        reset = 1'b1;
        tick(4);

        // 0xA5 with ready held high: one-clk valid, no flags
        ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        tick(4);
        @(negedge clk);
        check("s1_present",      n_present,  1);
        check("s1_valid_cycles", n_valid_hi, 1);
        check("s1_valid_low",    valid,      0);
        check("s1_busy",         busy,       0);
        check("s1_fe",           fe_cnt,     0);
        check("s1_ov",           ov_cnt,     0);

        // Glitch shorter than half a bit: false start
        tick(1);
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        @(negedge clk);
        check("s2_busy_hi", busy, 1);
        tick(20);
        @(negedge clk);
        check("s2_busy_lo", busy,      0);
        check("s2_present", n_present, 1);
        check("s2_fe",      fe_cnt,    0);

        // Low stop bit then a long break
        tick(1);
        send_frame(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        tick(40);
        @(negedge clk);
        check("s3_fe",       fe_cnt,    1);
        check("s3_valid",    valid,     0);
        check("s3_busy_hi",  busy,      1);
        check("s3_present",  n_present, 1);
        tick(1);
        rx = 1'b1;
        tick(5);
        @(negedge clk);
        check("s3_busy_lo",  busy,   0);
        check("s3_fe_once",  fe_cnt, 1);

        // Overrun: ready low, two frames back to back
        tick(1);
        ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        tick(4);
        @(negedge clk);
        check("s4_data",    {24'b0, data}, 32'h11);
        check("s4_valid",   valid,     1);
        check("s4_ov",      ov_cnt,    1);
        check("s4_present", n_present, 2);

        // Read and load on the same edge: no overrun, new byte replaces old
        tick(1);
        exp_q.push_back(8'h22);
        fork
            send_frame(8'h22, 1'b1, 1'b0);
            begin
                repeat (STOP_EDGE - 1) @(posedge clk);
                #1 ready = 1'b1;
                @(posedge clk);
                #1 ready = 1'b0;
            end
        join
        tick(4);
        @(negedge clk);
        check("s5_data",    {24'b0, data}, 32'h22);
        check("s5_valid",   valid,     1);
        check("s5_ov",      ov_cnt,    1);
        check("s5_present", n_present, 3);
        tick(1);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        @(negedge clk);
        check("s5_drain_valid", valid, 0);
        check("s5_drain_data",  {24'b0, data}, 32'h22);

        // Reset in the middle of the data bits of 0xFF, then a clean 0x5A
        tick(1);
        fork
            send_frame(8'hFF, 1'b1, 1'b1);
            begin
                tick(60);
                reset = 1'b0;
                tick(1);
                reset = 1'b1;
            end
        join
        tick(4);
        @(negedge clk);
        check("s6_valid",   valid,     0);
        check("s6_data",    {24'b0, data}, 32'h0);
        check("s6_busy",    busy,      0);
        check("s6_present", n_present, 3);
        tick(1);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b1);
        tick(4);
        @(negedge clk);
        check("s6_data_5a",  {24'b0, data}, 32'h5A);
        check("s6_valid_5a", valid,     1);
        check("s6_present2", n_present, 4);
`ifdef UART_RX_PARITY_EN
        check("s6_parity_err", pe_cnt, 1);
`endif

        check("end_queue_empty", exp_q.size(), 0);
        check("end_fe",          fe_cnt, 1);
        check("end_ov",          ov_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
